uart_rx_ctrl: RTL and testbench

UART receive controller for the CPU peripheral block. Oversamples the asynchronous serial line, frames 8N1 bytes and buffers them in a small FIFO. The CPU reads the FIFO through a pop strobe, and the block drives the LED byte and an interrupt request to the core. It sits between the external uart_in pin and the CPU peripheral bus inside cpu_perefery.

---
 rtl/uart_rx_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: two-flop input synchroniser, framing FSM, small show-ahead
// receive FIFO, sticky error flags, LED mirror of the last accepted byte and a level irq.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_in,
    input  logic                          rd_en,
    input  logic                          clr_err,
    input  logic                          irq_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          irq,
    output logic [7:0]                    leds
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    // ---- stage p0/p1: input synchroniser (idles high so reset never fakes a start bit)
    logic rx_sync_p0, rx_sync_p1, rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= uart_in;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rx_s = rx_sync_p1;

    // ---- framing FSM
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            push, ferr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Every bit is rewritten before a push, so the shift register needs no reset.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt            = '0;
                    shreg_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_nxt   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- receive FIFO, flags and irq
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          pop, full, accept;

    assign rx_valid = (count != '0);
    assign full     = (count == CNT_FULL);
    assign pop      = rd_en & rx_valid;
    // When full, a same-cycle pop frees the slot the push overwrites.
    assign accept   = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            leds      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= ptr_inc(wr_ptr);
                leds        <= shreg;
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + NW'(accept) - NW'(pop);

            if (push && !accept) overrun <= 1'b1;
            else if (clr_err)    overrun <= 1'b0;

            if (ferr_set)        frame_err <= 1'b1;
            else if (clr_err)    frame_err <= 1'b0;

            irq <= irq_en & rx_valid;
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a read-data
// scoreboard: bytes expected in the FIFO are queued as they are sent and popped on reads.
module tb_uart_rx_ctrl;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, uart_in, rd_en, clr_err, irq_en;
    logic [7:0] rd_data, leds;
    logic       rx_valid, overrun, frame_err, irq;
    logic [$clog2(DEPTH):0] rx_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_in(uart_in), .rd_en(rd_en), .clr_err(clr_err),
        .irq_en(irq_en), .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count),
        .overrun(overrun), .frame_err(frame_err), .irq(irq), .leds(leds)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every effective pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rd_en && rx_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected nothing", rd_data);
            end else begin
                check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Leaves uart_in at the stop level; returns just before the stop-sample edge.
    task automatic send_byte(input logic [7:0] d, input logic stop, input logic accepted);
        if (accepted) exp_q.push_back(d);
        uart_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_in = d[i];
            repeat (CPB) tick();
        end
        uart_in = stop;
        repeat (CPB) tick();
    endtask

    task automatic read_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; uart_in = 1'b1; rd_en = 1'b0; clr_err = 1'b0; irq_en = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_rd_data",   32'(rd_data),   32'h0);
        check("rst_rx_valid",  32'(rx_valid),  32'h0);
        check("rst_rx_count",  32'(rx_count),  32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_irq",       32'(irq),       32'h0);
        check("rst_leds",      32'(leds),      32'h0);

        // single byte with latency and irq timing
        idle(3);
        send_byte(8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        check("a5_valid_early", 32'(rx_valid), 32'h0);
        @(negedge clk);
        check("a5_valid",   32'(rx_valid), 32'h1);
        check("a5_rd_data", 32'(rd_data),  32'hA5);
        check("a5_leds",    32'(leds),     32'hA5);
        check("a5_irq_lag", 32'(irq),      32'h0);
        @(negedge clk);
        check("a5_irq", 32'(irq), 32'h1);
        tick();
        read_one();
        check("a5_count_after_pop", 32'(rx_count), 32'h0);
        check("a5_irq_hold",        32'(irq),      32'h1);
        tick();
        check("a5_irq_drop",        32'(irq),      32'h0);

        // glitch rejection and pop while empty
        uart_in = 1'b0;
        tick();
        uart_in = 1'b1;
        idle(10);
        check("glitch_count", 32'(rx_count),  32'h0);
        check("glitch_ferr",  32'(frame_err), 32'h0);
        read_one();
        check("empty_pop_count", 32'(rx_count), 32'h0);
        check("empty_pop_valid", 32'(rx_valid), 32'h0);

        // framing error, recovery, clear
        idle(3);
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(6);
        uart_in = 1'b1;
        idle(6);
        check("ferr_set",   32'(frame_err), 32'h1);
        check("ferr_count", 32'(rx_count),  32'h0);
        check("ferr_leds",  32'(leds),      32'hA5);
        send_byte(8'h81, 1'b1, 1'b1);
        idle(3);
        check("ferr_next_count", 32'(rx_count), 32'h1);
        check("ferr_next_leds",  32'(leds),     32'h81);
        read_one();
        check("ferr_sticky", 32'(frame_err), 32'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ferr_clear", 32'(frame_err), 32'h0);

        // overrun with five bytes, then drain and wrap
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, i <= DEPTH);
            idle(3);
        end
        check("ovr_count", 32'(rx_count), 32'h4);
        check("ovr_flag",  32'(overrun),  32'h1);
        check("ovr_leds",  32'(leds),     32'h04);
        repeat (4) read_one();
        check("ovr_drained", 32'(rx_count), 32'h0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_clear", 32'(overrun), 32'h0);
        send_byte(8'h06, 1'b1, 1'b1);
        idle(3);
        send_byte(8'h07, 1'b1, 1'b1);
        idle(3);
        check("wrap_count", 32'(rx_count), 32'h2);
        repeat (2) read_one();

        // simultaneous push and pop while full
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h11 + 8'(i), 1'b1, 1'b1);
            idle(3);
        end
        check("full_count", 32'(rx_count), 32'h4);
        send_byte(8'h10, 1'b1, 1'b1);
        read_one();
        check("pp_count",   32'(rx_count), 32'h4);
        check("pp_overrun", 32'(overrun),  32'h0);
        check("pp_leds",    32'(leds),     32'h10);
        idle(2);
        repeat (4) read_one();
        check("pp_drained", 32'(rx_count), 32'h0);

        // reset during DATA bit 3 of 8'hFF
        idle(3);
        uart_in = 1'b0;
        repeat (CPB) tick();
        uart_in = 1'b1;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 32'(rx_count), 32'h0);
        check("mid_rst_leds",  32'(leds),     32'h0);
        idle(8);
        check("mid_rst_no_push", 32'(rx_count), 32'h0);
        send_byte(8'h5A, 1'b1, 1'b1);
        idle(3);
        check("mid_rst_5a_count", 32'(rx_count), 32'h1);
        check("mid_rst_5a_leds",  32'(leds),     32'h5A);
        read_one();
        idle(2);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
